// File: rtl/tx_gen_pkg.sv
// Shared types and field layout for the TX test-frame generator and the RX detector.
package tx_gen_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFrame,
        StGap,
        StSkip,
        StDone
    } tx_state_e;

    // Default payload offsets of the stamping fields; the RX detector uses the same values.
    localparam int unsigned AUX_POS_DEF = 0;
    localparam int unsigned SEG_POS_DEF = 1;

    // Payload byte at index idx: aux byte, big-endian segment number, else idx ^ aux.
    function automatic logic [7:0] frame_byte(
        input logic [15:0] idx,
        input logic [7:0]  aux_val,
        input logic [15:0] seg_val,
        input logic [15:0] aux_pos,
        input logic [15:0] seg_pos
    );
        logic [7:0] b;
        if (idx == aux_pos) begin
            b = aux_val;
        end else if (idx == seg_pos) begin
            b = seg_val[15:8];
        end else if (idx == seg_pos + 16'd1) begin
            b = seg_val[7:0];
        end else begin
            b = idx[7:0] ^ aux_val;
        end
        return b;
    endfunction

endpackage

// File: rtl/aux_seg_counter.sv
// Aux/segment sequence counter: seg counts 0..segment_number_max-1, aux steps on each seg wrap.
// A segment_number_max of 0 behaves like 1 (every advance steps aux).
module aux_seg_counter
    import tx_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        advance,
    input  logic [15:0] segment_number_max,
    output logic [7:0]  aux,
    output logic [15:0] seg
);

    logic [7:0]  aux_q;
    logic [15:0] seg_q;
    logic        seg_wrap;

    assign seg_wrap = (segment_number_max <= 16'd1) || (seg_q == segment_number_max - 16'd1);

    // Sequence register: clear wins over advance; aux wraps naturally modulo 256.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            aux_q <= 8'd0;
            seg_q <= 16'd0;
        end else if (advance) begin
            if (seg_wrap) begin
                seg_q <= 16'd0;
                aux_q <= aux_q + 8'd1;
            end else begin
                seg_q <= seg_q + 16'd1;
            end
        end
    end

    assign aux = aux_q;
    assign seg = seg_q;

endmodule

// File: rtl/tx_seq_frame_gen.sv
// Test-frame transmitter: fixed-length payload frames stamped with aux/segment numbers,
// separated by IFG idle cycles. Optional frame-loss injection under TX_DROP_INJECT_EN.
module tx_seq_frame_gen
    import tx_gen_pkg::*;
#(
    parameter int unsigned AUX_POS   = AUX_POS_DEF,
    parameter int unsigned SEG_POS   = SEG_POS_DEF,
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned IFG       = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] segment_number_max,
    input  logic [31:0] frame_total,
    input  logic        tx_ready,
`ifdef TX_DROP_INJECT_EN
    input  logic [15:0] drop_period,
    output logic [31:0] dropped_count,
`endif
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic [7:0]  aux,
    output logic [15:0] seg,
    output logic [31:0] sent_count,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] LastIdx = 16'(FRAME_LEN - 1);
    localparam logic [15:0] GapLast = 16'(IFG - 1);
    localparam logic [15:0] AuxPos  = 16'(AUX_POS);
    localparam logic [15:0] SegPos  = 16'(SEG_POS);

    tx_state_e   state_q, state_d;
    logic [15:0] byte_idx_q, byte_idx_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] seg_max_q, seg_max_d;
    logic [31:0] frame_total_q, frame_total_d;
    logic [31:0] frames_issued_q, frames_issued_d;
    logic [31:0] sent_q, sent_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        seq_clear, seq_advance;
    logic        skip_first, skip_next;
    logic        last_issue;

    assign last_issue = (frames_issued_q + 32'd1) == frame_total_q;

`ifdef TX_DROP_INJECT_EN
    logic [15:0] drop_period_q, drop_period_d;
    logic [15:0] drop_ctr_q, drop_ctr_d, drop_ctr_inc;
    logic [31:0] dropped_q, dropped_d;

    // drop_ctr_q tracks frame index modulo drop_period; frame k drops when (k+1) % period == 0.
    assign drop_ctr_inc  = (drop_ctr_q == drop_period_q - 16'd1) ? 16'd0 : drop_ctr_q + 16'd1;
    assign skip_first    = (drop_period == 16'd1);
    assign skip_next     = (drop_period_q != 16'd0) && (drop_ctr_q == drop_period_q - 16'd1);
    assign dropped_count = dropped_q;
`else
    assign skip_first = 1'b0;
    assign skip_next  = 1'b0;
`endif

    aux_seg_counter u_seq (
        .clk                (clk),
        .rst                (rst),
        .clear              (seq_clear),
        .advance            (seq_advance),
        .segment_number_max (seg_max_q),
        .aux                (aux),
        .seg                (seg)
    );

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d         = state_q;
        byte_idx_d      = byte_idx_q;
        gap_cnt_d       = gap_cnt_q;
        seg_max_d       = seg_max_q;
        frame_total_d   = frame_total_q;
        frames_issued_d = frames_issued_q;
        sent_d          = sent_q;
        tx_en_d         = tx_en_q;
        tx_data_d       = tx_data_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        seq_clear       = 1'b0;
        seq_advance     = 1'b0;
`ifdef TX_DROP_INJECT_EN
        drop_period_d   = drop_period_q;
        drop_ctr_d      = drop_ctr_q;
        dropped_d       = dropped_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    seg_max_d       = segment_number_max;
                    frame_total_d   = frame_total;
                    frames_issued_d = 32'd0;
                    sent_d          = 32'd0;
                    byte_idx_d      = 16'd0;
                    seq_clear       = 1'b1;
`ifdef TX_DROP_INJECT_EN
                    drop_period_d   = drop_period;
                    drop_ctr_d      = 16'd0;
                    dropped_d       = 32'd0;
`endif
                    if (frame_total == 32'd0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else if (skip_first) begin
                        state_d = StSkip;
                        busy_d  = 1'b1;
                    end else begin
                        state_d   = StFrame;
                        busy_d    = 1'b1;
                        tx_en_d   = 1'b1;
                        // aux/seg are being cleared this cycle, so stamp with zeros.
                        tx_data_d = frame_byte(16'd0, 8'd0, 16'd0, AuxPos, SegPos);
                    end
                end
            end
            StFrame: begin
                if (tx_ready) begin
                    if (byte_idx_q == LastIdx) begin
                        byte_idx_d      = 16'd0;
                        sent_d          = sent_q + 32'd1;
                        frames_issued_d = frames_issued_q + 32'd1;
                        seq_advance     = 1'b1;
                        tx_en_d         = 1'b0;
`ifdef TX_DROP_INJECT_EN
                        drop_ctr_d      = drop_ctr_inc;
`endif
                        if (last_issue) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d   = StGap;
                            gap_cnt_d = 16'd0;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 16'd1;
                        tx_data_d  = frame_byte(byte_idx_q + 16'd1, aux, seg, AuxPos, SegPos);
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    if (skip_next) begin
                        state_d = StSkip;
                    end else begin
                        state_d   = StFrame;
                        tx_en_d   = 1'b1;
                        tx_data_d = frame_byte(16'd0, aux, seg, AuxPos, SegPos);
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
`ifdef TX_DROP_INJECT_EN
            StSkip: begin
                // Dropped frame consumes its sequence number without being sent.
                seq_advance     = 1'b1;
                frames_issued_d = frames_issued_q + 32'd1;
                dropped_d       = dropped_q + 32'd1;
                drop_ctr_d      = drop_ctr_inc;
                if (last_issue) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d   = StGap;
                    gap_cnt_d = 16'd0;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            byte_idx_q      <= 16'd0;
            gap_cnt_q       <= 16'd0;
            seg_max_q       <= 16'd0;
            frame_total_q   <= 32'd0;
            frames_issued_q <= 32'd0;
            sent_q          <= 32'd0;
            tx_en_q         <= 1'b0;
            tx_data_q       <= 8'd0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
`ifdef TX_DROP_INJECT_EN
            drop_period_q   <= 16'd0;
            drop_ctr_q      <= 16'd0;
            dropped_q       <= 32'd0;
`endif
        end else begin
            state_q         <= state_d;
            byte_idx_q      <= byte_idx_d;
            gap_cnt_q       <= gap_cnt_d;
            seg_max_q       <= seg_max_d;
            frame_total_q   <= frame_total_d;
            frames_issued_q <= frames_issued_d;
            sent_q          <= sent_d;
            tx_en_q         <= tx_en_d;
            tx_data_q       <= tx_data_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
`ifdef TX_DROP_INJECT_EN
            drop_period_q   <= drop_period_d;
            drop_ctr_q      <= drop_ctr_d;
            dropped_q       <= dropped_d;
`endif
        end
    end

    assign tx_en      = tx_en_q;
    assign tx_data    = tx_data_q;
    assign sent_count = sent_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_tx_seq_frame_gen.sv
// Directed self-checking bench for tx_seq_frame_gen (FRAME_LEN 64, IFG 12, offsets 0/1).
// Drop-injection scenario is compiled in when TX_DROP_INJECT_EN is defined.
module tb_tx_seq_frame_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] smn = 16'd0;
    logic [31:0] ftot = 32'd0;
    logic        tx_ready = 1'b1;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic [7:0]  aux;
    logic [15:0] seg;
    logic [31:0] sent_count;
    logic        busy;
    logic        done;
`ifdef TX_DROP_INJECT_EN
    logic [15:0] drop_period = 16'd0;
    logic [31:0] dropped_count;
`endif

    int total = 0;
    int bad = 0;

    tx_seq_frame_gen dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .segment_number_max (smn),
        .frame_total        (ftot),
        .tx_ready           (tx_ready),
`ifdef TX_DROP_INJECT_EN
        .drop_period        (drop_period),
        .dropped_count      (dropped_count),
`endif
        .tx_en              (tx_en),
        .tx_data            (tx_data),
        .aux                (aux),
        .seg                (seg),
        .sent_count         (sent_count),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    // Stream monitor: records (aux,seg) of each frame's first byte and tallies anomalies.
    logic [7:0]  mon_aux[$];
    logic [15:0] mon_seg[$];
    int mon_idx = 0, mon_frames = 0, mon_run_frames = 0, mon_low_run = 0;
    int mon_byte_err = 0, mon_len_err = 0, mon_gap_err = 0, mon_hold_err = 0;
    logic mon_prev_en = 1'b0, mon_prev_stall = 1'b0;
    logic [7:0] mon_prev_data = 8'd0, mon_exp;

    always @(negedge clk) begin
        if (rst) begin
            mon_idx = 0; mon_prev_en = 1'b0; mon_prev_stall = 1'b0;
            mon_low_run = 0; mon_run_frames = 0;
        end else begin
            if (!busy) begin
                mon_low_run = 0; mon_run_frames = 0;
            end
            if (tx_en) begin
                if (!mon_prev_en && mon_run_frames > 0 && mon_low_run != 12) mon_gap_err++;
                mon_low_run = 0;
                if (mon_prev_stall && tx_data !== mon_prev_data) mon_hold_err++;
                if (mon_idx == 0) mon_exp = aux;
                else if (mon_idx == 1) mon_exp = seg[15:8];
                else if (mon_idx == 2) mon_exp = seg[7:0];
                else mon_exp = 8'(mon_idx) ^ aux;
                if (tx_data !== mon_exp) mon_byte_err++;
                if (tx_ready) begin
                    if (mon_idx == 0) begin
                        mon_aux.push_back(aux);
                        mon_seg.push_back(seg);
                    end
                    mon_idx++;
                    if (mon_idx == 64) begin
                        mon_idx = 0; mon_frames++; mon_run_frames++;
                    end
                    mon_prev_stall = 1'b0;
                end else begin
                    mon_prev_stall = 1'b1;
                    mon_prev_data = tx_data;
                end
            end else begin
                if (mon_prev_en && mon_idx != 0) mon_len_err++;
                if (busy) mon_low_run++;
                mon_prev_stall = 1'b0;
            end
            mon_prev_en = tx_en;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] m, input logic [31:0] n);
        smn = m; ftot = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Steps until done is seen; last_acc is whether a byte was accepted the cycle before.
    task automatic wait_done(input int limit, output bit seen, output bit last_acc);
        seen = 1'b0;
        last_acc = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                return;
            end
            last_acc = (tx_en === 1'b1) && (tx_ready === 1'b1);
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
        tick(); tick();
        total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL reset_tx_en got=%0b want=0", tx_en); end
        total++; if (tx_data !== 8'd0) begin bad++; $display("FAIL reset_tx_data got=%0h want=0", tx_data); end
        total++; if ({aux, seg} !== 24'd0) begin bad++; $display("FAIL reset_aux_seg got=%0d,%0d want=0,0", aux, seg); end
        total++; if (sent_count !== 32'd0) begin bad++; $display("FAIL reset_sent got=%0d want=0", sent_count); end
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got=%b want=00", {busy, done}); end
`ifdef TX_DROP_INJECT_EN
        total++; if (dropped_count !== 32'd0) begin bad++; $display("FAIL reset_dropped got=%0d want=0", dropped_count); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sequence;
        int q0 = mon_aux.size();
        int be0 = mon_byte_err, ge0 = mon_gap_err, le0 = mon_len_err;
        bit seen, acc;
        pulse_start(16'd3, 32'd7);
        total++; if ({tx_en, busy} !== 2'b11) begin bad++; $display("FAIL seq_first_cycle tx_en,busy got=%b want=11", {tx_en, busy}); end
        total++; if (tx_data !== 8'd0) begin bad++; $display("FAIL seq_first_byte got=%0h want=0", tx_data); end
        wait_done(1000, seen, acc);
        total++; if (!seen) begin bad++; $display("FAIL seq_done_timeout got=none want=done"); end
        total++; if (!acc) begin bad++; $display("FAIL seq_done_latency got=no_prior_byte want=byte_prev_cycle"); end
        total++; if (sent_count !== 32'd7) begin bad++; $display("FAIL seq_sent got=%0d want=7", sent_count); end
        total++; if ({busy, tx_en} !== 2'b00) begin bad++; $display("FAIL seq_busy_at_done got=%b want=00", {busy, tx_en}); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL seq_done_pulse got=%0b want=0", done); end
        total++; if (mon_aux.size() - q0 != 7) begin bad++; $display("FAIL seq_frames got=%0d want=7", mon_aux.size() - q0); end
        for (int i = 0; i < 7 && q0 + i < mon_aux.size(); i++) begin
            total++;
            if (mon_aux[q0+i] !== 8'(i / 3) || mon_seg[q0+i] !== 16'(i % 3)) begin
                bad++;
                $display("FAIL seq_stamp[%0d] got=(%0d,%0d) want=(%0d,%0d)", i, mon_aux[q0+i], mon_seg[q0+i], i / 3, i % 3);
            end
        end
        total++; if (mon_byte_err != be0) begin bad++; $display("FAIL seq_payload errors got=%0d want=0", mon_byte_err - be0); end
        total++; if (mon_gap_err != ge0) begin bad++; $display("FAIL seq_ifg errors got=%0d want=0", mon_gap_err - ge0); end
        total++; if (mon_len_err != le0) begin bad++; $display("FAIL seq_frame_len errors got=%0d want=0", mon_len_err - le0); end
    endtask

    task automatic test_aux_wrap;
        int q0 = mon_aux.size();
        int be0 = mon_byte_err;
        int segnz = 0;
        bit seen, acc;
        pulse_start(16'd1, 32'd258);
        wait_done(25000, seen, acc);
        total++; if (!seen) begin bad++; $display("FAIL wrap_done_timeout got=none want=done"); end
        total++; if (sent_count !== 32'd258) begin bad++; $display("FAIL wrap_sent got=%0d want=258", sent_count); end
        total++; if (mon_aux.size() - q0 != 258) begin bad++; $display("FAIL wrap_frames got=%0d want=258", mon_aux.size() - q0); end
        if (mon_aux.size() - q0 == 258) begin
            total++; if (mon_aux[q0+255] !== 8'd255) begin bad++; $display("FAIL wrap_aux255 got=%0d want=255", mon_aux[q0+255]); end
            total++; if (mon_aux[q0+256] !== 8'd0) begin bad++; $display("FAIL wrap_aux256 got=%0d want=0", mon_aux[q0+256]); end
            total++; if (mon_aux[q0+257] !== 8'd1) begin bad++; $display("FAIL wrap_aux257 got=%0d want=1", mon_aux[q0+257]); end
            for (int i = q0; i < mon_seg.size(); i++) if (mon_seg[i] !== 16'd0) segnz++;
            total++; if (segnz != 0) begin bad++; $display("FAIL wrap_seg_zero nonzero=%0d want=0", segnz); end
        end
        total++; if (mon_byte_err != be0) begin bad++; $display("FAIL wrap_payload errors got=%0d want=0", mon_byte_err - be0); end
        tick();
    endtask

    task automatic test_stall;
        int f0 = mon_frames, be0 = mon_byte_err, le0 = mon_len_err, he0 = mon_hold_err;
        bit seen, acc, found;
        found = 1'b0;
        pulse_start(16'd1, 32'd3);
        for (int i = 0; i < 400 && !found; i++) begin
            if (tx_en === 1'b1 && aux === 8'd2) found = 1'b1;
            else tick();
        end
        total++; if (!found) begin bad++; $display("FAIL stall_find_frame2 got=timeout want=frame2"); end
        for (int i = 0; i < 10; i++) tick();
        tx_ready = 1'b0;
        total++; if (tx_data !== 8'd8) begin bad++; $display("FAIL stall_byte10 got=%0h want=08", tx_data); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (tx_en !== 1'b1 || tx_data !== 8'd8) begin
                bad++; $display("FAIL stall_hold[%0d] got=en%0b,%0h want=en1,08", i, tx_en, tx_data);
            end
        end
        tx_ready = 1'b1;
        tick();
        total++; if (tx_data !== 8'd9) begin bad++; $display("FAIL stall_byte11 got=%0h want=09", tx_data); end
        wait_done(1000, seen, acc);
        total++; if (!seen || sent_count !== 32'd3) begin bad++; $display("FAIL stall_sent got=%0d want=3", sent_count); end
        total++; if (mon_frames - f0 != 3) begin bad++; $display("FAIL stall_frames got=%0d want=3", mon_frames - f0); end
        total++; if (mon_len_err != le0) begin bad++; $display("FAIL stall_frame_len errors got=%0d want=0", mon_len_err - le0); end
        total++; if (mon_hold_err != he0) begin bad++; $display("FAIL stall_hold_mon errors got=%0d want=0", mon_hold_err - he0); end
        total++; if (mon_byte_err != be0) begin bad++; $display("FAIL stall_payload errors got=%0d want=0", mon_byte_err - be0); end
        tick();
    endtask

    task automatic test_reset_mid;
        bit seen, acc, found;
        found = 1'b0;
        pulse_start(16'd3, 32'd5);
        for (int i = 0; i < 600 && !found; i++) begin
            if (tx_en === 1'b1 && aux === 8'd1) found = 1'b1;
            else tick();
        end
        total++; if (!found) begin bad++; $display("FAIL rstmid_find_frame3 got=timeout want=frame3"); end
        for (int i = 0; i < 20; i++) tick();
        total++; if (tx_data !== 8'd21 || sent_count !== 32'd3) begin bad++; $display("FAIL rstmid_pre got=%0h,%0d want=15,3", tx_data, sent_count); end
        rst = 1'b1;
        tick();
        total++; if ({tx_en, tx_data} !== 9'd0) begin bad++; $display("FAIL rstmid_tx got=en%0b,%0h want=en0,00", tx_en, tx_data); end
        total++; if ({aux, seg} !== 24'd0) begin bad++; $display("FAIL rstmid_seq got=%0d,%0d want=0,0", aux, seg); end
        total++; if ({sent_count, busy, done} !== 34'd0) begin bad++; $display("FAIL rstmid_status got=%0d,%0b,%0b want=0,0,0", sent_count, busy, done); end
        rst = 1'b0;
        tick();
        pulse_start(16'd3, 32'd1);
        total++; if (tx_en !== 1'b1 || {aux, seg} !== 24'd0) begin bad++; $display("FAIL rstmid_restart got=en%0b,(%0d,%0d) want=en1,(0,0)", tx_en, aux, seg); end
        wait_done(200, seen, acc);
        total++; if (!seen || sent_count !== 32'd1) begin bad++; $display("FAIL rstmid_rerun_sent got=%0d want=1", sent_count); end
        tick();
    endtask

    task automatic test_start_busy;
        int q0 = mon_aux.size();
        bit seen, acc, found;
        logic [7:0]  ea [3];
        logic [15:0] es [3];
        ea[0] = 8'd0; ea[1] = 8'd0; ea[2] = 8'd1;
        es[0] = 16'd0; es[1] = 16'd1; es[2] = 16'd0;
        pulse_start(16'd2, 32'd3);
        for (int i = 0; i < 30; i++) tick();
        pulse_start(16'd1, 32'd1);
        total++; if ({tx_en, busy} !== 2'b11 || sent_count !== 32'd0) begin bad++; $display("FAIL busy_start_frame got=%b,%0d want=11,0", {tx_en, busy}, sent_count); end
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (tx_en === 1'b0) found = 1'b1;
            else tick();
        end
        pulse_start(16'd1, 32'd1);
        total++; if (!found || busy !== 1'b1 || sent_count !== 32'd1) begin bad++; $display("FAIL busy_start_gap got=busy%0b,%0d want=busy1,1", busy, sent_count); end
        wait_done(500, seen, acc);
        total++; if (!seen || sent_count !== 32'd3) begin bad++; $display("FAIL busy_sent got=%0d want=3", sent_count); end
        total++; if (mon_aux.size() - q0 != 3) begin bad++; $display("FAIL busy_frames got=%0d want=3", mon_aux.size() - q0); end
        for (int i = 0; i < 3 && q0 + i < mon_aux.size(); i++) begin
            total++;
            if (mon_aux[q0+i] !== ea[i] || mon_seg[q0+i] !== es[i]) begin
                bad++; $display("FAIL busy_stamp[%0d] got=(%0d,%0d) want=(%0d,%0d)", i, mon_aux[q0+i], mon_seg[q0+i], ea[i], es[i]);
            end
        end
        tick();
    endtask

    task automatic test_zero_frames;
        int f0 = mon_aux.size();
        pulse_start(16'd3, 32'd0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%0b want=1", done); end
        total++; if ({tx_en, busy} !== 2'b00) begin bad++; $display("FAIL zero_tx_busy got=%b want=00", {tx_en, busy}); end
        tick();
        total++; if ({done, tx_en} !== 2'b00) begin bad++; $display("FAIL zero_after got=%b want=00", {done, tx_en}); end
        total++; if (mon_aux.size() != f0) begin bad++; $display("FAIL zero_no_frames got=%0d want=0", mon_aux.size() - f0); end
    endtask

`ifdef TX_DROP_INJECT_EN
    task automatic test_drop;
        int q0 = mon_aux.size();
        bit seen, acc;
        logic [7:0]  ea [6];
        logic [15:0] es [6];
        ea[0] = 8'd0; ea[1] = 8'd0; ea[2] = 8'd1; ea[3] = 8'd2; ea[4] = 8'd2; ea[5] = 8'd3;
        es[0] = 16'd0; es[1] = 16'd1; es[2] = 16'd0; es[3] = 16'd0; es[4] = 16'd1; es[5] = 16'd0;
        drop_period = 16'd4;
        pulse_start(16'd2, 32'd8);
        wait_done(1500, seen, acc);
        total++; if (!seen) begin bad++; $display("FAIL drop_done_timeout got=none want=done"); end
        total++; if (sent_count !== 32'd6) begin bad++; $display("FAIL drop_sent got=%0d want=6", sent_count); end
        total++; if (dropped_count !== 32'd2) begin bad++; $display("FAIL drop_dropped got=%0d want=2", dropped_count); end
        total++; if (mon_aux.size() - q0 != 6) begin bad++; $display("FAIL drop_frames got=%0d want=6", mon_aux.size() - q0); end
        for (int i = 0; i < 6 && q0 + i < mon_aux.size(); i++) begin
            total++;
            if (mon_aux[q0+i] !== ea[i] || mon_seg[q0+i] !== es[i]) begin
                bad++; $display("FAIL drop_stamp[%0d] got=(%0d,%0d) want=(%0d,%0d)", i, mon_aux[q0+i], mon_seg[q0+i], ea[i], es[i]);
            end
        end
        drop_period = 16'd0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_aux_wrap();
        test_stall();
        test_reset_mid();
        test_start_busy();
        test_zero_frames();
`ifdef TX_DROP_INJECT_EN
        test_drop();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_seq_frame_gen.md
# tx_seq_frame_gen

Test-frame transmitter for the link error-measurement path. It emits fixed-length payload frames as a byte stream, stamping each frame with an 8-bit aux sequence number and a 16-bit segment number. The aux number advances once every `segment_number_max` segments. The block sits on the TX side, ahead of the MAC/PHY byte interface, and produces exactly the stamping pattern the RX-side error detector checks to count ok, ng and lost frames.

## Interface
- `AUX_POS`, default 0: payload byte offset of the aux byte.
- `SEG_POS`, default 1: payload byte offset of the segment number, 2 bytes, big-endian (high byte at `SEG_POS`).
- `FRAME_LEN`, default 64: payload bytes per frame. Must be ≥ `SEG_POS`+2 and ≤ 65535.
- `IFG`, default 12: idle cycles between frames, with `tx_en` low. Must be ≥ 1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to start a run. Ignored unless in IDLE.
- `segment_number_max`  in  16  segments per aux value. 0 is treated as 1. Sampled on accepted `start`.
- `frame_total`  in  32  number of frames in the run. Sampled on accepted `start`.
- `tx_ready`  in  1  downstream accepts the current byte this cycle.
- `tx_en`  out  1  frame byte valid.
- `tx_data`  out  8  frame byte.
- `aux`  out  8  aux number of the current frame.
- `seg`  out  16  segment number of the current frame.
- `sent_count`  out  32  frames fully transmitted.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the run completes.

## Operation
- States:
  - IDLE: accepts `start`. Latches `segment_number_max` and `frame_total`, clears `aux`, `seg`, `sent_count` and `byte_idx`.
    - `frame_total`==0 → DONE.
    - Otherwise → FRAME.
  - FRAME: `tx_en`=1. A byte is accepted when `tx_en`&&`tx_ready`, which increments `byte_idx`.
    - On the accepted byte with `byte_idx`==`FRAME_LEN`-1: `sent_count`+1, advance the sequence, clear `byte_idx`.
    - Then → DONE if `frames_issued`==`frame_total`, else → GAP.
  - GAP: `tx_en`=0 for `IFG` cycles, then → FRAME.
  - DONE: `done`=1 for one cycle, then → IDLE.
- Byte content by `byte_idx`:
  - `AUX_POS` → `aux`.
  - `SEG_POS` → `seg[15:8]`.
  - `SEG_POS`+1 → `seg[7:0]`.
  - Any other index → `byte_idx[7:0]` ^ `aux`.
- Sequence advance:
  - If `seg`==`segment_number_max`-1: `seg`←0 and `aux`←`aux`+1. `aux` wraps modulo 256 (255→0).
  - Else `seg`←`seg`+1.
- `frames_issued` is an internal 32-bit counter of generated frames, sent or dropped.
- Downstream stall: `tx_data` is held while `tx_ready` is low. A stall never ends a frame early.
- `start` while busy: ignored, with no effect on any counter.
- Reset mid-operation: state returns to IDLE. Registers reset as listed below.
- Reset values: `tx_en`=0, `tx_data`=0, `aux`=0, `seg`=0, `sent_count`=0, `busy`=0, `done`=0.

## Timing
- All outputs are registered.
- `tx_en` rises one cycle after the accepted `start`. The first byte is `byte_idx` 0.
- With `tx_ready` held high, a frame is `FRAME_LEN` consecutive `tx_en` cycles, followed by exactly `IFG` low cycles.
- `aux` and `seg` update in the cycle after the last byte is accepted and are stable for the whole next frame.
- `done` asserts one cycle after the last accepted byte of the run. `busy` drops in the same cycle as `done`.
- A `frame_total`==0 run: `done` asserts one cycle after `start`, and `tx_en` never rises.

## Configuration
- `TX_DROP_INJECT_EN`: deliberate frame-loss injection.
- With the macro defined:
  - Adds input `drop_period` (16 bits, sampled on `start`) and output `dropped_count` (32 bits, reset to 0).
  - A frame with index k (0-based) is skipped when `drop_period`≠0 and (k+1) mod `drop_period`==0.
  - A skipped frame occupies one SKIP-state cycle with `tx_en` low: sequence advances, `frames_issued`+1, `dropped_count`+1, then GAP or DONE.
- Without the macro: no ports, no SKIP state, every frame is transmitted.

## Structure
- Package `tx_gen_pkg` holds:
  - The state enum (IDLE, FRAME, GAP, SKIP, DONE).
  - Default field offsets `AUX_POS_DEF`, `SEG_POS_DEF`, shared with the RX detector.
- Sub-module `aux_seg_counter` holds `aux`/`seg`, with inputs `clear`, `advance`, `segment_number_max` and outputs `aux`, `seg`. The RX checker's expected-next logic reuses it.

## Test plan
- `segment_number_max`=3, `frame_total`=7 → (aux,seg) sequence (0,0),(0,1),(0,2),(1,0),(1,1),(1,2),(2,0); `sent_count`=7; one `done` pulse.
- `segment_number_max`=1, `frame_total`=258 → frame 255 aux=255, frame 256 aux=0, frame 257 aux=1; `seg` always 0.
- `tx_ready` low for 5 cycles at `byte_idx`=10 → `tx_data` held; the frame still carries 64 bytes; byte 10 equals 10^aux.
- `rst` asserted at `byte_idx`=20 → next cycle `tx_en`=0 and every output at its reset value; the next `start` restarts at (0,0).
- `start` pulsed mid-run → ignored, counts unchanged. `frame_total`=0 → `done` one cycle after `start`, no `tx_en`.
- With `TX_DROP_INJECT_EN`, `drop_period`=4, `frame_total`=8, `segment_number_max`=2 → frames 3 and 7 skipped; `sent_count`=6; `dropped_count`=2; the transmitted seq omits (1,1) and (3,1).
